// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Latency: 3-5 cycles per instruction plus one cycle per low mem_ready_i cycle in FETCH/MEMREAD/MEMWRITE.
// Backpressure: stalls in memory states until mem_ready_i; TRAP holds until reset.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   opcode_i                instruction opcode, stable from DECODE onward
//   zero_i                  ALU zero flag, only looked at in BRANCH
//   mem_ready_i             unified memory port completes the access this cycle
//   PCWrite_o .. ImmSrc_o   datapath strobes and mux selects
//   instr_retired_o         pulse on the last cycle of each instruction
//   illegal_o               high while parked in TRAP
// Optional build macro CTRL_PERF_CNT_EN adds cycle_count_o / instret_count_o.

module multicycle_control_fsm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        AdrSrc_o,
  output logic        IRWrite_o,
  output logic        MemWrite_o,
  output logic        RegWrite_o,
  output logic [1:0]  ResultSrc_o,
  output logic [1:0]  ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic [2:0]  ImmSrc_o,
  output logic        instr_retired_o,
  output logic        illegal_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count_o,
  output logic [31:0] instret_count_o
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  state_e state_q, state_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      // JALR computes its target, then reuses JAL for the PC load and link value.
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_UPPER:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // Only latch the instruction and advance PC once memory returns it.
        ir_write   = mem_ready_i;
        pc_update  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_UPPER: begin
        // LUI adds the immediate to zero, AUIPC to the instruction's own PC.
        alu_src_a = (opcode_i == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      S_TRAP:    illegal = 1'b1;
      default: ;
    endcase

    // Reset gates strobes combinationally so a pending write drops immediately;
    // selects are parked on their FETCH values.
    if (rst_i) begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      illegal    = 1'b0;
      result_src = 2'b10;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      alu_op     = 2'b00;
    end

    PCWrite_o       = pc_update | (branch & zero_i);
    AdrSrc_o        = adr_src;
    IRWrite_o       = ir_write;
    MemWrite_o      = mem_write;
    RegWrite_o      = reg_write;
    ResultSrc_o     = result_src;
    ALUSrcA_o       = alu_src_a;
    ALUSrcB_o       = alu_src_b;
    ALUOp_o         = alu_op;
    illegal_o       = illegal;
    instr_retired_o = !rst_i && (state_q != S_FETCH) && (state_d == S_FETCH);
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (opcode_i)
      OP_LOAD, OP_JALR, OP_ITYPE: ImmSrc_o = 3'b000;
      OP_STORE:                   ImmSrc_o = 3'b001;
      OP_BRANCH:                  ImmSrc_o = 3'b010;
      OP_JAL:                     ImmSrc_o = 3'b011;
      OP_LUI, OP_AUIPC:           ImmSrc_o = 3'b100;
      default:                    ImmSrc_o = 3'b000;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instret_count_q, instret_count_d;

  always_comb begin
    cycle_count_d   = cycle_count_q + 32'd1;
    instret_count_d = instret_count_q + {31'd0, instr_retired_o};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_count_q   <= 32'd0;
      instret_count_q <= 32'd0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cycle_count_o   = cycle_count_q;
  assign instret_count_o = instret_count_q;
`endif

endmodule
